// File: rtl/psx_poll_sequencer_if.sv
// ---------------------------------------------------------------------------
// psx_poll_sequencer_if : byte handshake between poll sequencer and SPI master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface psx_poll_sequencer_if;
  logic       xfer_req;
  logic [7:0] xfer_tx;
  logic       xfer_done;
  logic [7:0] xfer_rx;

  modport master (output xfer_req, output xfer_tx, input xfer_done, input xfer_rx);
  modport slave  (input xfer_req, input xfer_tx, output xfer_done, output xfer_rx);
endinterface

`default_nettype wire

// File: rtl/psx_poll_sequencer.sv
// ---------------------------------------------------------------------------
// psx_poll_sequencer : periodic PSX gamepad poll frame sequencer (ATT, 5 bytes)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module psx_poll_sequencer #(
  parameter int POLL_CYCLES = 20000,
  parameter int ATT_SETUP   = 64,
  parameter int GAP_CYCLES  = 32,
  parameter int TIMEOUT     = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  psx_poll_sequencer_if.master        spi,
  output logic                        att_n,
  output logic [15:0]                 buttons,
  output logic [7:0]                  ctrl_id,
  output logic                        frame_valid,
  output logic                        frame_err
);

  localparam int MAX_A = (POLL_CYCLES > ATT_SETUP) ? POLL_CYCLES : ATT_SETUP;
  localparam int MAX_B = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(ATT_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_POLL = 3'd0,
    SETUP     = 3'd1,
    REQ       = 3'd2,
    GAP       = 3'd3,
    CHECK     = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      tx_byte;
  logic [7:0]      rx1, rx2, rx3;
  logic            done_hit, timeout_hit;

  function automatic logic [7:0] tx_lookup(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h01;
      3'd1:    return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

  assign done_hit    = (state == REQ) && spi.xfer_done;
  assign timeout_hit = (state == REQ) && !spi.xfer_done && (cnt == TMO_LAST);
  assign spi.xfer_tx = tx_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_POLL;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    att_n        = 1'b1;
    spi.xfer_req = 1'b0;
    case (state)
      WAIT_POLL: if (cnt == POLL_LAST) state_next = SETUP;
      SETUP: begin
        att_n = 1'b0;
        if (cnt == SETUP_LAST) state_next = REQ;
      end
      REQ: begin
        att_n        = 1'b0;
        spi.xfer_req = 1'b1;
        // A done arriving on the last timeout cycle still completes the byte.
        if (spi.xfer_done)    state_next = (idx == 3'd4) ? CHECK : GAP;
        else if (timeout_hit) state_next = WAIT_POLL;
      end
      GAP: begin
        att_n = 1'b0;
        if (cnt == GAP_LAST) state_next = REQ;
      end
      CHECK:   state_next = WAIT_POLL;
      default: state_next = WAIT_POLL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 3'd0;
      tx_byte     <= 8'h00;
      rx1         <= 8'h00;
      rx2         <= 8'h00;
      rx3         <= 8'h00;
      buttons     <= 16'h0000;
      ctrl_id     <= 8'h00;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      cnt         <= (state_next != state) ? '0 : cnt + 1'b1;

      if (state == WAIT_POLL && state_next == SETUP) begin
        idx     <= 3'd0;
        tx_byte <= tx_lookup(3'd0);
      end

      // Index and next TX byte advance as xfer_req drops, so xfer_tx never moves under a request.
      if (done_hit) begin
        if (idx != 3'd4) begin
          case (idx)
            3'd1:    rx1 <= spi.xfer_rx;
            3'd2:    rx2 <= spi.xfer_rx;
            3'd3:    rx3 <= spi.xfer_rx;
            default: ;
          endcase
          idx     <= idx + 3'd1;
          tx_byte <= tx_lookup(idx + 3'd1);
        end else if (rx2 == 8'h5A) begin
          buttons     <= {~spi.xfer_rx, ~rx3};
          ctrl_id     <= rx1;
          frame_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end

      if (timeout_hit) frame_err <= 1'b1;

      if (state_next == WAIT_POLL && state != WAIT_POLL) tx_byte <= 8'h00;
    end
  end

endmodule

`default_nettype wire
